// File: rtl/ctrl_isa_pkg.sv
// Shared ISA definitions for the instruction encoder.
// Contents: opcode values, 20-bit word field positions, encoder FSM state type,
// and a branch-offset range helper.
package ctrl_isa_pkg;

  localparam int OPC_W     = 4;
  localparam int REG_W     = 4;
  localparam int ALU_IMM_W = 8;
  localparam int MADDR_W   = 10;
  localparam int JIMM_W    = 12;
  localparam int LEFT_W    = 16;
  localparam int WORD_W    = 20;

  // Field positions inside inst_left
  localparam int F_HI_MSB  = 15;  // dest (LOAD/ALU) or src1 (BR/STORE)
  localparam int F_HI_LSB  = 12;
  localparam int F_MID_MSB = 11;  // src1 (ALU) or src2 (BR)
  localparam int F_MID_LSB = 8;
  localparam int F_LO_MSB  = 7;   // src2 (ALU-R)
  localparam int F_LO_LSB  = 4;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SUBI  = 4'b0110;
  localparam logic [3:0] OP_ANDI  = 4'b0111;
  localparam logic [3:0] OP_ORI   = 4'b1000;
  localparam logic [3:0] OP_BEQ   = 4'b1001;
  localparam logic [3:0] OP_BNE   = 4'b1010;
  localparam logic [3:0] OP_BLT   = 4'b1011;
  localparam logic [3:0] OP_BGE   = 4'b1100;
  localparam logic [3:0] OP_JUMP  = 4'b1101;
  localparam logic [3:0] OP_BLTU  = 4'b1110;
  localparam logic [3:0] OP_STORE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } enc_state_e;

  // A branch offset fits when bits [11:8] are the sign extension of bit 7
  function automatic logic branch_in_range(input logic [JIMM_W-1:0] jimm);
    return (jimm[11:8] == {4{jimm[7]}});
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: opcode plus decoded fields -> 20-bit instruction word
// {opc, inst_left}. Unused inst_left bits are zero. range_err flags a branch
// whose offset does not fit the 8-bit signed field.
module instr_field_packer
  import ctrl_isa_pkg::*;
(
  input  logic [OPC_W-1:0]     opc,
  input  logic [REG_W-1:0]     reg_dest,
  input  logic [REG_W-1:0]     reg_src1,
  input  logic [REG_W-1:0]     reg_src2,
  input  logic [ALU_IMM_W-1:0] imm,
  input  logic [MADDR_W-1:0]   mem_addr,
  input  logic [JIMM_W-1:0]    jump_imm,
  output logic [WORD_W-1:0]    word,
  output logic                 range_err
);

  logic [LEFT_W-1:0] left_s;
  logic              range_err_s;

  // Select the field layout for the opcode class
  always_comb begin
    left_s      = {LEFT_W{1'b0}};
    range_err_s = 1'b0;
    case (opc)
      OP_LOAD: begin
        left_s[F_HI_MSB:F_HI_LSB] = reg_dest;
        left_s[MADDR_W-1:0]       = mem_addr;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        left_s[F_HI_MSB:F_HI_LSB]   = reg_dest;
        left_s[F_MID_MSB:F_MID_LSB] = reg_src1;
        left_s[F_LO_MSB:F_LO_LSB]   = reg_src2;
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        left_s[F_HI_MSB:F_HI_LSB]   = reg_dest;
        left_s[F_MID_MSB:F_MID_LSB] = reg_src1;
        left_s[ALU_IMM_W-1:0]       = imm;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU: begin
        left_s[F_HI_MSB:F_HI_LSB]   = reg_src1;
        left_s[F_MID_MSB:F_MID_LSB] = reg_src2;
        left_s[7:0]                 = jump_imm[7:0];
        range_err_s                 = ~branch_in_range(jump_imm);
      end
      OP_JUMP: begin
        left_s[JIMM_W-1:0] = jump_imm;
      end
      OP_STORE: begin
        left_s[F_HI_MSB:F_HI_LSB] = reg_src1;
        left_s[MADDR_W-1:0]       = mem_addr;
      end
      default: begin
        left_s      = {LEFT_W{1'b0}};
        range_err_s = 1'b0;
      end
    endcase
  end

  assign word      = {opc, left_s};
  assign range_err = range_err_s;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded instructions over a valid/ready
// handshake, packs them and writes them to instruction memory at an
// auto-incrementing address starting from base_addr.
// Optional feature macro: ENC_CHECKSUM_EN adds csum[19:0], the XOR of all
// words written since the last start.
module instr_encoder
  import ctrl_isa_pkg::*;
#(
  parameter int N  = 3,
  parameter int M  = 15,
  parameter int J  = 9,
  parameter int K  = 7,
  parameter int L  = 11,
  parameter int AW = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  base_addr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_last,
  input  logic [N:0]     opc,
  input  logic [N:0]     reg_dest,
  input  logic [N:0]     reg_src1,
  input  logic [N:0]     reg_src2,
  input  logic [K:0]     imm,
  input  logic [J:0]     mem_addr,
  input  logic [L:0]     jump_imm,
  output logic           im_we,
  output logic [AW-1:0]  im_addr,
  output logic [M+N+1:0] im_wdata,
  output logic [AW:0]    instr_cnt,
  output logic           done,
  output logic           err
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [M+N+1:0] csum
`endif
);

  enc_state_e          state_r;
  enc_state_e          state_nxt_s;
  logic [AW-1:0]       pc_r;
  logic [AW:0]         cnt_r;
  logic                err_r;
  logic                we_r;
  logic [AW-1:0]       addr_r;
  logic [M+N+1:0]      wdata_r;
  logic [M+N+1:0]      word_s;
  logic                range_err_s;
  logic                accept_s;
  logic                start_s;
  logic                pc_max_s;

  instr_field_packer u_packer (
    .opc       (opc),
    .reg_dest  (reg_dest),
    .reg_src1  (reg_src1),
    .reg_src2  (reg_src2),
    .imm       (imm),
    .mem_addr  (mem_addr),
    .jump_imm  (jump_imm),
    .word      (word_s),
    .range_err (range_err_s)
  );

  // start is only honoured from IDLE, and in IDLE no handshake can occur
  assign start_s  = start && (state_r == ST_IDLE);
  assign accept_s = in_valid && (state_r == ST_RUN);
  assign pc_max_s = (pc_r == {AW{1'b1}});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: finish on last word, range error or top-of-memory write
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && (range_err_s || in_last || pc_max_s)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Write pipeline, pc, word count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= {AW{1'b0}};
      cnt_r   <= {(AW+1){1'b0}};
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {(M+N+2){1'b0}};
    end else begin
      we_r <= 1'b0;
      if (start_s) begin
        pc_r  <= base_addr;
        cnt_r <= {(AW+1){1'b0}};
        err_r <= 1'b0;
      end else if (accept_s) begin
        if (range_err_s) begin
          err_r <= 1'b1;
        end else begin
          we_r    <= 1'b1;
          addr_r  <= pc_r;
          wdata_r <= word_s;
          cnt_r   <= cnt_r + {{AW{1'b0}}, 1'b1};
          // The top address is written once, then the run stops without wrapping
          if (pc_max_s) begin
            err_r <= 1'b1;
          end else begin
            pc_r <= pc_r + {{(AW-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [M+N+1:0] csum_r;

  // Running XOR of every word written since start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= {(M+N+2){1'b0}};
    end else if (start_s) begin
      csum_r <= {(M+N+2){1'b0}};
    end else if (accept_s && !range_err_s) begin
      csum_r <= csum_r ^ word_s;
    end
  end

  assign csum = csum_r;
`endif

  assign in_ready  = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);
  assign err       = err_r;
  assign im_we     = we_r;
  assign im_addr   = addr_r;
  assign im_wdata  = wdata_r;
  assign instr_cnt = cnt_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed instructions push their
// expected (address, word) into a queue; a negedge monitor pops and compares
// on every im_we. Status outputs are checked directly by the stimulus thread.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = 10'h000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  opc = 4'h0;
  logic [3:0]  reg_dest = 4'h0;
  logic [3:0]  reg_src1 = 4'h0;
  logic [3:0]  reg_src2 = 4'h0;
  logic [7:0]  imm = 8'h00;
  logic [9:0]  mem_addr = 10'h000;
  logic [11:0] jump_imm = 12'h000;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [19:0] im_wdata;
  logic [10:0] instr_cnt;
  logic        done;
  logic        err;
`ifdef ENC_CHECKSUM_EN
  logic [19:0] csum;
`endif

  typedef struct packed {
    logic [9:0]  a;
    logic [19:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .opc       (opc),
    .reg_dest  (reg_dest),
    .reg_src1  (reg_src1),
    .reg_src2  (reg_src2),
    .imm       (imm),
    .mem_addr  (mem_addr),
    .jump_imm  (jump_imm),
    .im_we     (im_we),
    .im_addr   (im_addr),
    .im_wdata  (im_wdata),
    .instr_cnt (instr_cnt),
    .done      (done),
    .err       (err)
`ifdef ENC_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && im_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", im_addr, im_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {22'd0, im_addr}, {22'd0, e.a});
        check("wr_data", {12'd0, im_wdata}, {12'd0, e.d});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the start edge
  task automatic do_start(input logic [9:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offer one instruction; returns at posedge+1 after the accepting edge
  task automatic send(input logic [3:0] o, input logic [3:0] d, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [7:0] im, input logic [9:0] ma,
                      input logic [11:0] ji, input logic last, input logic exp_wr,
                      input logic [9:0] exp_a, input logic [19:0] exp_d);
    logic accepted;
    exp_t e;
    opc = o; reg_dest = d; reg_src1 = s1; reg_src2 = s2;
    imm = im; mem_addr = ma; jump_imm = ji; in_last = last;
    in_valid = 1'b1;
    if (exp_wr) begin
      e.a = exp_a;
      e.d = exp_d;
      exp_q.push_back(e);
    end
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready expected accept of opc %h", o);
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_im_we", {31'd0, im_we}, 32'd0);
    check("rst_instr_cnt", {21'd0, instr_cnt}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LOAD as single-instruction program
    do_start(10'h010);
    send(4'h0, 4'd3, 4'd0, 4'd0, 8'h00, 10'h155, 12'h000, 1'b1, 1'b1, 10'h010, 20'h03155);
    check("load_done", {31'd0, done}, 32'd1);
    check("load_cnt", {21'd0, instr_cnt}, 32'd1);
    @(posedge clk);
    #1;

    // ALU-R / ALU-I back-to-back, ignored start in RUN, good and bad branch
    do_start(10'h010);
    send(4'h1, 4'd1, 4'd2, 4'd3, 8'h00, 10'h000, 12'h000, 1'b0, 1'b1, 10'h010, 20'h11230);
    send(4'h5, 4'd4, 4'd5, 4'd0, 8'hA7, 10'h000, 12'h000, 1'b0, 1'b1, 10'h011, 20'h545A7);
    do_start(10'h300);
    check("run_start_ignored", {30'd0, in_ready, done}, 32'd2);
    send(4'h9, 4'd0, 4'd2, 4'd7, 8'h00, 10'h000, 12'hFF0, 1'b0, 1'b1, 10'h012, 20'h927F0);
    send(4'h9, 4'd0, 4'd2, 4'd7, 8'h00, 10'h000, 12'h080, 1'b0, 1'b0, 10'h000, 20'h00000);
    check("br_range_done", {31'd0, done}, 32'd1);
    check("br_range_err", {31'd0, err}, 32'd1);
    check("br_range_cnt", {21'd0, instr_cnt}, 32'd3);
    check("br_range_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("err_sticky", {31'd0, err}, 32'd1);
    check("done_pulse1", {31'd0, done}, 32'd0);

    // JUMP then STORE with in_last
    do_start(10'h020);
    check("start_clr_err", {31'd0, err}, 32'd0);
    check("start_clr_cnt", {21'd0, instr_cnt}, 32'd0);
    send(4'hD, 4'd0, 4'd0, 4'd0, 8'h00, 10'h000, 12'hABC, 1'b0, 1'b1, 10'h020, 20'hD0ABC);
    send(4'hF, 4'd0, 4'd6, 4'd0, 8'h00, 10'h3FF, 12'h000, 1'b1, 1'b1, 10'h021, 20'hF63FF);
    check("store_done", {31'd0, done}, 32'd1);
    check("store_cnt", {21'd0, instr_cnt}, 32'd2);
    check("store_err", {31'd0, err}, 32'd0);
`ifdef ENC_CHECKSUM_EN
    check("csum", {12'd0, csum}, 32'h00026943);
`endif
    @(posedge clk);
    #1;
    check("done_pulse2", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("cnt_hold", {21'd0, instr_cnt}, 32'd2);

    // Address overflow at the top of instruction memory
    do_start(10'h3FF);
    send(4'h6, 4'd7, 4'd8, 4'd0, 8'h3C, 10'h000, 12'h000, 1'b0, 1'b1, 10'h3FF, 20'h6783C);
    check("ovf_done", {31'd0, done}, 32'd1);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_cnt", {21'd0, instr_cnt}, 32'd1);
    opc = 4'h1; reg_dest = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_no_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Reset in the middle of a run drops the pending write
    do_start(10'h100);
    check("restart_clr_err", {31'd0, err}, 32'd0);
    send(4'h0, 4'd1, 4'd0, 4'd0, 8'h00, 10'h001, 12'h000, 1'b0, 1'b1, 10'h100, 20'h01001);
    send(4'hF, 4'd0, 4'd2, 4'd0, 8'h00, 10'h002, 12'h000, 1'b0, 1'b1, 10'h101, 20'hF2002);
    send(4'h1, 4'd3, 4'd4, 4'd5, 8'h00, 10'h000, 12'h000, 1'b0, 1'b0, 10'h000, 20'h00000);
    check("pre_rst_we", {31'd0, im_we}, 32'd1);
    check("pre_rst_cnt", {21'd0, instr_cnt}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, im_we}, 32'd0);
    check("mid_rst_cnt", {21'd0, instr_cnt}, 32'd0);
    check("mid_rst_done_err", {30'd0, done, err}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
`ifdef ENC_CHECKSUM_EN
    check("mid_rst_csum", {12'd0, csum}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
